// File: rtl/mp64_phy_pkg.sv
// Shared types and constants for the Megapad-64 external-memory PHY model.
package mp64_phy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAT,
    ST_RDATA,
    ST_WDATA,
    ST_REFRESH
  } phy_state_e;

  localparam int PHY_BURST_W = 4;
  localparam int PHY_DEFAULT_DATA_W = 64;

  // Number of address bits that select a byte within one data beat.
  function automatic int byte_off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  localparam int PHY_BYTE_OFF_W = byte_off_w(PHY_DEFAULT_DATA_W);

endpackage

// File: rtl/mp64_phy_mem_model_if.sv
// Request/beat bus between the SoC memory port and the PHY model.
interface mp64_phy_mem_model_if
  import mp64_phy_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
);
  logic                   phy_req;
  logic [ADDR_W-1:0]      phy_addr;
  logic                   phy_wen;
  logic [DATA_W-1:0]      phy_wdata;
  logic [PHY_BURST_W-1:0] phy_burst_len;
  logic [DATA_W-1:0]      phy_rdata;
  logic                   phy_rvalid;
  logic                   phy_wack;
  logic                   phy_ready;
  logic                   phy_err;

  modport master (
    output phy_req, phy_addr, phy_wen, phy_wdata, phy_burst_len,
    input  phy_rdata, phy_rvalid, phy_wack, phy_ready, phy_err
  );

  modport slave (
    input  phy_req, phy_addr, phy_wen, phy_wdata, phy_burst_len,
    output phy_rdata, phy_rvalid, phy_wack, phy_ready, phy_err
  );
endinterface

// File: rtl/mp64_phy_refresh_timer.sv
// Free-running refresh period counter with a sticky pending flag.
module mp64_phy_refresh_timer #(
  parameter int PERIOD = 0
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic refresh_ack,
  output logic refresh_pending
);
  generate
    if (PERIOD == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs   = sys_clk ^ sys_rst_n ^ refresh_ack;
      assign refresh_pending = 1'b0;
    end else begin : g_on
      logic [31:0] cnt_reg;
      logic        pending_reg;

      // A new period elapsing wins over a same-cycle acknowledge, so no request is lost.
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          cnt_reg     <= '0;
          pending_reg <= 1'b0;
        end else if (cnt_reg == 32'(PERIOD - 1)) begin
          cnt_reg     <= '0;
          pending_reg <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + 32'd1;
          if (refresh_ack) pending_reg <= 1'b0;
        end
      end

      assign refresh_pending = pending_reg;
    end
  endgenerate
endmodule

// File: rtl/mp64_phy_mem_model.sv
// External-memory PHY model: latency, bursts, range errors, refresh stalls, beat counters.
module mp64_phy_mem_model
  import mp64_phy_pkg::*;
#(
  parameter int    DATA_W         = 64,
  parameter int    ADDR_W         = 32,
  parameter int    DEPTH          = 32768,
  parameter int    RD_LAT         = 2,
  parameter int    WR_LAT         = 2,
  parameter int    REFRESH_PERIOD = 0,
  parameter int    REFRESH_CYCLES = 4,
  parameter string INIT_FILE      = ""
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  mp64_phy_mem_model_if.slave  phy,
  output logic [31:0]          rd_beats,
  output logic [31:0]          wr_beats
);
  localparam int OFF_W  = byte_off_w(DATA_W);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam int MEM_AW = $clog2(DEPTH);
  localparam int LAT_W  = 16;

  logic [DATA_W-1:0] mem [DEPTH];

  phy_state_e             state_reg;
  logic [LAT_W-1:0]       lat_cnt_reg;
  logic [LAT_W-1:0]       ref_cnt_reg;
  logic [PHY_BURST_W-1:0] beat_cnt_reg;
  logic [IDX_W-1:0]       idx_reg;
  logic                   wen_reg;
  logic                   rvalid_reg, wack_reg, err_reg;
  logic [DATA_W-1:0]      rdata_reg;
  logic [31:0]            rd_beats_reg, wr_beats_reg;

  logic             refresh_pending, refresh_ack;
  logic [IDX_W-1:0] req_idx;
  logic [LAT_W-1:0] lat_load;
  logic             beat_next, beat_wen_next, beat_oor_next;
  logic [IDX_W-1:0] beat_idx_next;
  logic             unused_addr_lsbs;

  mp64_phy_refresh_timer #(.PERIOD(REFRESH_PERIOD)) u_refresh (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .refresh_ack     (refresh_ack),
    .refresh_pending (refresh_pending)
  );

  assign phy.phy_ready     = (state_reg == ST_IDLE) && !refresh_pending;
  assign req_idx           = phy.phy_addr[ADDR_W-1:OFF_W];
  assign unused_addr_lsbs  = ^phy.phy_addr[OFF_W-1:0];
  assign lat_load          = phy.phy_wen ? LAT_W'(WR_LAT - 1) : LAT_W'(RD_LAT - 1);
  assign refresh_ack       = (state_reg == ST_REFRESH) && (ref_cnt_reg == '0);

  // Describes the beat that will be presented after the coming edge, so all beat outputs can be registered.
  always_comb begin
    beat_next     = 1'b0;
    beat_idx_next = idx_reg;
    beat_wen_next = wen_reg;
    case (state_reg)
      ST_IDLE: begin
        if (phy.phy_ready && phy.phy_req && lat_load == '0) begin
          beat_next     = 1'b1;
          beat_idx_next = req_idx;
          beat_wen_next = phy.phy_wen;
        end
      end
      ST_LAT:   beat_next = (lat_cnt_reg == LAT_W'(1));
      ST_RDATA,
      ST_WDATA: begin
        if (beat_cnt_reg != '0) begin
          beat_next     = 1'b1;
          beat_idx_next = idx_reg + IDX_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign beat_oor_next = (beat_idx_next >> MEM_AW) != '0;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg    <= ST_IDLE;
      lat_cnt_reg  <= '0;
      ref_cnt_reg  <= '0;
      beat_cnt_reg <= '0;
      idx_reg      <= '0;
      wen_reg      <= 1'b0;
      rvalid_reg   <= 1'b0;
      wack_reg     <= 1'b0;
      err_reg      <= 1'b0;
      rdata_reg    <= '0;
      rd_beats_reg <= '0;
      wr_beats_reg <= '0;
    end else begin
      rvalid_reg <= beat_next && !beat_wen_next;
      wack_reg   <= beat_next && beat_wen_next;
      err_reg    <= beat_next && beat_oor_next;
      if (beat_next && !beat_wen_next && !beat_oor_next)
        rdata_reg <= mem[beat_idx_next[MEM_AW-1:0]];
      else
        rdata_reg <= '0;

      case (state_reg)
        ST_IDLE: begin
          if (refresh_pending) begin
            state_reg   <= ST_REFRESH;
            ref_cnt_reg <= LAT_W'(REFRESH_CYCLES - 1);
          end else if (phy.phy_req) begin
            idx_reg      <= req_idx;
            beat_cnt_reg <= phy.phy_burst_len;
            wen_reg      <= phy.phy_wen;
            lat_cnt_reg  <= lat_load;
            if (lat_load == '0) state_reg <= phy.phy_wen ? ST_WDATA : ST_RDATA;
            else                state_reg <= ST_LAT;
          end
        end
        ST_LAT: begin
          lat_cnt_reg <= lat_cnt_reg - LAT_W'(1);
          if (lat_cnt_reg == LAT_W'(1)) state_reg <= wen_reg ? ST_WDATA : ST_RDATA;
        end
        ST_RDATA,
        ST_WDATA: begin
          if (state_reg == ST_RDATA) rd_beats_reg <= rd_beats_reg + 32'd1;
          else                       wr_beats_reg <= wr_beats_reg + 32'd1;
          if (beat_cnt_reg == '0) begin
            state_reg <= ST_IDLE;
          end else begin
            beat_cnt_reg <= beat_cnt_reg - PHY_BURST_W'(1);
            idx_reg      <= idx_reg + IDX_W'(1);
          end
        end
        ST_REFRESH: begin
          if (ref_cnt_reg == '0) state_reg <= ST_IDLE;
          else                   ref_cnt_reg <= ref_cnt_reg - LAT_W'(1);
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // No reset here: contents survive a reset.
  always_ff @(posedge sys_clk) begin
    if (state_reg == ST_WDATA && (idx_reg >> MEM_AW) == '0)
      mem[idx_reg[MEM_AW-1:0]] <= phy.phy_wdata;
  end

  assign phy.phy_rdata  = rdata_reg;
  assign phy.phy_rvalid = rvalid_reg;
  assign phy.phy_wack   = wack_reg;
  assign phy.phy_err    = err_reg;
  assign rd_beats       = rd_beats_reg;
  assign wr_beats       = wr_beats_reg;
endmodule

// File: doc/mp64_phy_mem_model.md
# mp64_phy_mem_model

Parametrised external-memory PHY model for Megapad-64 SoC simulation. It sits on the SoC `phy_*` port in place of an inline testbench stub. Relative to the fixed-latency stub, it adds:
- independent configurable read and write latency;
- a write-beat acknowledge;
- address wrap and out-of-range error reporting;
- optional periodic refresh stalls;
- beat counters.

It is synthesizable, apart from the optional `$readmemh` preload.

## Interface
- `DATA_W`, 64: data beat width; must be a multiple of 8.
- `ADDR_W`, 32: byte address width.
- `DEPTH`, 32768: number of memory words; power of two.
- `RD_LAT`, 2: cycles from request accept to first read beat; minimum 1.
- `WR_LAT`, 2: cycles from request accept to first write beat; minimum 1.
- `REFRESH_PERIOD`, 0: cycles between refresh requests; 0 disables refresh.
- `REFRESH_CYCLES`, 4: stall length per refresh; minimum 1.
- `INIT_FILE`, "": hex preload file; an empty string means no preload.

Ports:
- `sys_clk`  in  1  single clock; all logic is on its rising edge.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `phy_req`  in  1  transfer request; sampled only while `phy_ready`=1.
- `phy_addr`  in  ADDR_W  byte address of the first beat; low log2(DATA_W/8) bits are ignored.
- `phy_wen`  in  1  1 = write, 0 = read; sampled at accept.
- `phy_wdata`  in  DATA_W  write data for the current beat.
- `phy_burst_len`  in  4  beats minus 1 (0 to 15); sampled at accept.
- `phy_rdata`  out  DATA_W  read data, valid while `phy_rvalid`=1.
- `phy_rvalid`  out  1  read beat strobe.
- `phy_wack`  out  1  current `phy_wdata` is written at the next edge.
- `phy_ready`  out  1  idle and able to accept a request.
- `phy_err`  out  1  one-cycle pulse per out-of-range beat.
- `rd_beats`  out  32  total read beats since reset; wraps.
- `wr_beats`  out  32  total write beats since reset; wraps.

## Operation
States:
- IDLE: `phy_ready`=1 unless a refresh is pending.
- LAT: latency countdown.
- RDATA: read beats.
- WDATA: write beats.
- REFRESH: refresh stall.

Transitions:
- IDLE with refresh pending → REFRESH. Refresh wins over a simultaneous `phy_req`, and `phy_ready` is already 0 in that cycle.
- IDLE with `phy_req`&&`phy_ready` → accept. Latch the word index = `phy_addr` >> log2(DATA_W/8), the beat count, and `phy_wen`. Load the latency counter with RD_LAT-1 or WR_LAT-1. Go to LAT; if the loaded value is 0, go directly to RDATA or WDATA.
- LAT: decrement each cycle; at 0 go to RDATA or WDATA.
- RDATA: one beat per cycle with no gaps. `phy_rdata` = mem[index] and `phy_rvalid`=1.
- WDATA: `phy_wack`=1 each beat, and mem[index] ← `phy_wdata` at the edge.
- After each beat in RDATA or WDATA: index ← index+1. When the beat count reaches 0, return to IDLE.

Address and range rules:
- The index is ADDR_W-3 bits wide and does not wrap at DEPTH.
- A beat whose index is ≥ DEPTH is out of range:
  - a read returns 0;
  - a write is dropped;
  - `phy_err` pulses in that beat cycle;
  - the beat still counts in `rd_beats` or `wr_beats`.

Refresh:
- With REFRESH_PERIOD>0, a free-running counter sets the refresh pending flag every REFRESH_PERIOD cycles.
- The pending flag is honoured only in IDLE; bursts are never split.
- REFRESH lasts REFRESH_CYCLES cycles, then returns to IDLE and clears the pending flag.
- If the period elapses again while a refresh is still pending, the requests merge into one.

Input changes mid-burst: changes to `phy_req`, `phy_addr`, `phy_wen` and `phy_burst_len` after accept are ignored.

Reset (asynchronous, also mid-burst):
- state → IDLE;
- `phy_ready`=1, `phy_rvalid`=0, `phy_wack`=0, `phy_err`=0;
- `phy_rdata`=0;
- counters = 0, refresh counter = 0, refresh pending = 0;
- memory contents are preserved.

## Timing
- Accept happens at edge N.
- First read beat: `phy_rvalid`=1 in the cycle following edge N+RD_LAT-1. With RD_LAT=2, the beat is visible after edge N+1.
- First write beat: `phy_wack`=1 in the cycle following edge N+WR_LAT-1.
- The requester advances `phy_wdata` after each edge at which `phy_wack` was 1.
- `phy_ready` returns to 1 in the cycle after the last beat, so back-to-back requests have one idle cycle between them.
- `phy_rvalid`, `phy_wack` and `phy_err` are registered, state-derived outputs; no input-to-output combinational paths exist.

## Structure
- Shared package `mp64_phy_pkg`: state enum, `PHY_BURST_W`=4, and the byte-offset constant derived from DATA_W.
- One natural sub-module: `mp64_phy_refresh_timer` (period counter plus pending flag, with an acknowledge input).
- The memory array and `INIT_FILE` preload stay in the top module.

## Test plan
- Single read, RD_LAT=2: preload mem[4]=0xDEADBEEF, request addr 0x20 with burst 0 → one `phy_rvalid` beat with 0xDEADBEEF; `phy_ready` low for exactly 2 cycles; `rd_beats`=1.
- Write burst, WR_LAT=3: write addr 0x100 with burst_len 3 and data 1,2,3,4 advanced on `phy_wack` → first `phy_wack` at accept+3, 4 consecutive acks; a read-back returns 1,2,3,4; `wr_beats`=4.
- Out of range, DEPTH=16: read addr 0x78 with burst_len 1 → beat 0 returns mem[15]; beat 1 (index 16) returns 0 with `phy_err` pulsed once.
- Refresh collision, REFRESH_PERIOD=50 and REFRESH_CYCLES=4: assert `phy_req` on the cycle refresh becomes pending → 4-cycle stall, then the request is accepted; a burst in flight when the period elapses completes unbroken before the refresh.
- Reset mid-burst: assert `sys_rst_n`=0 during beat 2 of a 16-beat read → `phy_rvalid`=0 and `phy_ready`=1 immediately; counters are 0; memory is intact on read-back.
